dlfloat_result_serializer: RTL



---
 rtl/dlfloat_pkg.sv | 18 +
 rtl/dlfloat_result_fifo.sv | 64 ++++++
 rtl/dlfloat_result_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions (sign 1, exponent 6, mantissa 9) and the
// serializer control-state encoding.
package dlfloat_pkg;

  localparam int DLF_W     = 16;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;

  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_CAPTURE = 2'b10
  } dlf_state_e;

endpackage

// File: rtl/dlfloat_result_fifo.sv
// Synchronous register FIFO holding captured accumulator results; head is the
// oldest entry, count is the number of queued entries.
module dlfloat_result_fifo
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DLF_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard against overflow/underflow even though the caller never requests them.
  assign push_ok_s = push && (count_r != CNT_FULL);
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/dlfloat_result_serializer.sv
// Counts operand pairs sent to the DLFloat16 MAC, captures each finished dot
// product, clears the MAC and streams queued results out high byte first.
module dlfloat_result_serializer
  import dlfloat_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int LAT     = 3,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pair_valid,
  output logic                   pair_ready,
  input  logic [DLF_W-1:0]       acc_in,
  output logic                   acc_clr,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   byte_last,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_err
);

  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int DLY_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int FCNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0]  PAIR_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(LAT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

  dlf_state_e        state_r;
  dlf_state_e        state_nxt_s;
  logic [CNT_W-1:0]  pair_cnt_r;
  logic [CNT_W-1:0]  pair_cnt_nxt_s;
  logic [DLY_W-1:0]  dly_r;
  logic [DLY_W-1:0]  dly_nxt_s;
  logic              phase_lo_r;
  logic              drop_err_r;
  logic              accept_s;
  logic              xfer_s;
  logic              push_s;
  logic              pop_s;
  logic [DLF_W-1:0]  head_s;
  logic [DLF_W-1:0]  head_vis_s;
  logic [FCNT_W-1:0] count_s;

  assign pair_ready = (state_r == ST_IDLE) && (count_s < FIFO_FULL);
  assign accept_s   = pair_valid && pair_ready;
  assign push_s     = (state_r == ST_CAPTURE);
  assign acc_clr    = push_s;
  assign byte_valid = (count_s != {FCNT_W{1'b0}});
  assign xfer_s     = byte_valid && byte_ready;
  assign pop_s      = xfer_s && phase_lo_r;
  assign byte_last  = byte_valid && phase_lo_r;
  assign fifo_count = count_s;
  assign drop_err   = drop_err_r;

  dlfloat_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DLF_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (acc_in),
    .head    (head_s),
    .count   (count_s)
  );

  // Byte selection; an empty queue presents zero rather than stale storage.
  always_comb begin
    head_vis_s = DLF_ZERO;
    if (byte_valid) begin
      head_vis_s = head_s;
    end else begin
      head_vis_s = DLF_ZERO;
    end
    byte_out = phase_lo_r ? head_vis_s[7:0] : head_vis_s[15:8];
  end

  // Next-state logic for the pair counter and the wait/capture sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    pair_cnt_nxt_s = pair_cnt_r;
    dly_nxt_s      = dly_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (pair_cnt_r == PAIR_LAST)) begin
          pair_cnt_nxt_s = {CNT_W{1'b0}};
          dly_nxt_s      = DLY_INIT;
          state_nxt_s    = ST_WAIT;
        end else if (accept_s) begin
          pair_cnt_nxt_s = pair_cnt_r + CNT_W'(1);
        end else begin
          pair_cnt_nxt_s = pair_cnt_r;
        end
      end
      ST_WAIT: begin
        if (dly_r == {DLY_W{1'b0}}) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          dly_nxt_s = dly_r - DLY_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        pair_cnt_nxt_s = {CNT_W{1'b0}};
        dly_nxt_s      = {DLY_W{1'b0}};
      end
    endcase
  end

  // Control registers, byte phase and the sticky rejected-pair flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pair_cnt_r <= {CNT_W{1'b0}};
      dly_r      <= {DLY_W{1'b0}};
      phase_lo_r <= 1'b0;
      drop_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pair_cnt_r <= pair_cnt_nxt_s;
      dly_r      <= dly_nxt_s;
      if (xfer_s) begin
        phase_lo_r <= ~phase_lo_r;
      end
      if (pair_valid && !pair_ready) begin
        drop_err_r <= 1'b1;
      end
    end
  end

endmodule
